// File: rtl/fp_cop1_pkg.sv
// COP1 single-precision issue block: encoding constants, ALU control codes, FSM state codes and decoder.
package fp_cop1_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [5:0] OPC_COP1 = 6'b010001;
   localparam logic [4:0] FMT_S    = 5'b10000;
   localparam logic [4:0] FMT_BC   = 5'b01000;
   localparam int         BC_TF_BIT = 16;

   localparam logic [5:0] FN_ADD = 6'b000000;
   localparam logic [5:0] FN_SUB = 6'b000001;
   localparam logic [5:0] FN_MOV = 6'b000110;
   localparam logic [5:0] FN_CEQ = 6'b110010;
   localparam logic [5:0] FN_CLT = 6'b111100;
   localparam logic [5:0] FN_CLE = 6'b111110;

   localparam logic [2:0] ALU_IDLE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b011;
   localparam logic [2:0] ALU_MOV  = 3'b100;
   localparam logic [2:0] ALU_CEQ  = 3'b101;
   localparam logic [2:0] ALU_CLT  = 3'b110;
   localparam logic [2:0] ALU_CLE  = 3'b111;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_DECODE = 2'b01;
   localparam logic [1:0] ST_EXEC   = 2'b10;
   localparam logic [1:0] ST_WB     = 2'b11;

   typedef enum logic [1:0] {
      OP_ILLEGAL = 2'b00,
      OP_ARITH   = 2'b01,
      OP_CMP     = 2'b10,
      OP_BRANCH  = 2'b11
   } op_kind_e;

   typedef struct packed {
      op_kind_e             kind;
      logic [2:0]           ctrl;
      logic [REG_IDX_W-1:0] fs;
      logic [REG_IDX_W-1:0] ft;
      logic [REG_IDX_W-1:0] fd;
   } dec_t;

   // Branch forms are only recognised when br_en is set; otherwise they fall through as illegal.
   function automatic dec_t decode_instr(input logic [31:0] w, input logic br_en);
      dec_t d;
      d.kind = OP_ILLEGAL;
      d.ctrl = ALU_IDLE;
      d.ft   = w[20:16];
      d.fs   = w[15:11];
      d.fd   = w[10:6];
      if ((w[31:26] == OPC_COP1) && (w[25:21] == FMT_S)) begin
         case (w[5:0])
            FN_ADD:  begin d.kind = OP_ARITH; d.ctrl = ALU_ADD; end
            FN_SUB:  begin d.kind = OP_ARITH; d.ctrl = ALU_SUB; end
            FN_MOV:  begin d.kind = OP_ARITH; d.ctrl = ALU_MOV; end
            FN_CEQ:  begin d.kind = OP_CMP;   d.ctrl = ALU_CEQ; end
            FN_CLT:  begin d.kind = OP_CMP;   d.ctrl = ALU_CLT; end
            FN_CLE:  begin d.kind = OP_CMP;   d.ctrl = ALU_CLE; end
            default: begin d.kind = OP_ILLEGAL; d.ctrl = ALU_IDLE; end
         endcase
      end else if (br_en && (w[31:26] == OPC_COP1) && (w[25:21] == FMT_BC)) begin
         d.kind = OP_BRANCH;
      end else begin
         d.kind = OP_ILLEGAL;
      end
      return d;
   endfunction

endpackage

// File: rtl/fp_regfile.sv
// FP register file: two operand read ports, a store read port, load and writeback write ports.
module fp_regfile
   import fp_cop1_pkg::*;
#(
   parameter int NUM_FPR = 32,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_a_addr,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_b_data,
   input  logic [ADDR_W-1:0] st_addr,
   output logic [DATA_W-1:0] st_data,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   logic [DATA_W-1:0] mem_r [NUM_FPR];

   assign rd_a_data = mem_r[rd_a_addr];
   assign rd_b_data = mem_r[rd_b_addr];
   assign st_data   = mem_r[st_addr];

   // Storage update; writeback is ordered last so it wins a same-address collision with a load.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FPR; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (ld_we) begin
            mem_r[ld_addr] <= ld_data;
         end
         if (wb_we) begin
            mem_r[wb_addr] <= wb_data;
         end
      end
   end

endmodule

// File: rtl/fp_cop1_issue.sv
// COP1 issue/writeback sequencer for the single-precision FP ALU.
// Optional bc1t/bc1f support via the FPCC_BRANCH_EN macro.
module fp_cop1_issue
   import fp_cop1_pkg::*;
#(
   parameter int NUM_FPR = 32,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   output logic              done,
   output logic              illegal,
   output logic [2:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_cmp,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [ADDR_W-1:0] st_addr,
   output logic [DATA_W-1:0] st_data,
   output logic              fcc
`ifdef FPCC_BRANCH_EN
   ,
   output logic              br_valid,
   output logic              br_taken
`endif
);

`ifdef FPCC_BRANCH_EN
   localparam logic BR_EN = 1'b1;
`else
   localparam logic BR_EN = 1'b0;
`endif

   logic [1:0]        state_r;
   dec_t              dec_s;
   dec_t              dec_r;
   logic [DATA_W-1:0] rd_fs_s;
   logic [DATA_W-1:0] rd_ft_s;
   logic [DATA_W-1:0] res_r;
   logic              cmp_r;
   logic              wb_we_s;

   assign dec_s   = decode_instr(instr, BR_EN);
   assign wb_we_s = (state_r == ST_WB) && (dec_r.kind == OP_ARITH);

   fp_regfile #(
      .NUM_FPR (NUM_FPR),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_a_addr (dec_r.fs),
      .rd_a_data (rd_fs_s),
      .rd_b_addr (dec_r.ft),
      .rd_b_data (rd_ft_s),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .wb_we     (wb_we_s),
      .wb_addr   (dec_r.fd),
      .wb_data   (res_r)
   );

   // Sequencer: accept, operand fetch, result capture, writeback; pulses are cleared every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         in_ready <= 1'b1;
         dec_r    <= '0;
         alu_ctrl <= ALU_IDLE;
         alu_a    <= '0;
         alu_b    <= '0;
         res_r    <= '0;
         cmp_r    <= 1'b0;
         done     <= 1'b0;
         illegal  <= 1'b0;
         fcc      <= 1'b0;
`ifdef FPCC_BRANCH_EN
         br_valid <= 1'b0;
         br_taken <= 1'b0;
`endif
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
`ifdef FPCC_BRANCH_EN
         br_valid <= 1'b0;
         br_taken <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  dec_r    <= dec_s;
                  state_r  <= ST_DECODE;
                  in_ready <= 1'b0;
                  illegal  <= (dec_s.kind == OP_ILLEGAL);
`ifdef FPCC_BRANCH_EN
                  br_valid <= (dec_s.kind == OP_BRANCH);
                  br_taken <= (dec_s.kind == OP_BRANCH) && (fcc == instr[BC_TF_BIT]);
`endif
               end
            end
            ST_DECODE: begin
               if ((dec_r.kind == OP_ARITH) || (dec_r.kind == OP_CMP)) begin
                  alu_ctrl <= dec_r.ctrl;
                  // mov.s presents its source on data2 with data1 forced to zero
                  if (dec_r.ctrl == ALU_MOV) begin
                     alu_a <= '0;
                     alu_b <= rd_fs_s;
                  end else begin
                     alu_a <= rd_fs_s;
                     alu_b <= rd_ft_s;
                  end
                  state_r <= ST_EXEC;
               end else begin
                  state_r  <= ST_IDLE;
                  in_ready <= 1'b1;
               end
            end
            ST_EXEC: begin
               res_r   <= alu_result;
               cmp_r   <= alu_cmp;
               done    <= 1'b1;
               state_r <= ST_WB;
            end
            ST_WB: begin
               if (dec_r.kind == OP_CMP) begin
                  fcc <= cmp_r;
               end
               alu_ctrl <= ALU_IDLE;
               state_r  <= ST_IDLE;
               in_ready <= 1'b1;
            end
            default: begin
               alu_ctrl <= ALU_IDLE;
               state_r  <= ST_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_cop1_issue.sv
// Self-checking bench for fp_cop1_issue: directed cases with literal expectations plus random traffic
// compared every cycle against a transaction-level model (build with FPCC_BRANCH_EN for branch ports).
module tb_fp_cop1_issue;

   localparam int K_ILL = 0;
   localparam int K_ALU = 1;
   localparam int K_BR  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        ld_we = 1'b0;
   logic [4:0]  ld_addr = 5'd0;
   logic [31:0] ld_data = 32'h0;
   logic [4:0]  st_addr = 5'd0;
   logic        in_ready, done, illegal, alu_cmp, fcc;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_result, st_data;
`ifdef FPCC_BRANCH_EN
   logic        br_valid, br_taken;
`endif

   always #5 clk = ~clk;

   fp_cop1_issue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .done(done), .illegal(illegal), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_cmp(alu_cmp), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_data(ld_data), .st_addr(st_addr), .st_data(st_data), .fcc(fcc)
`ifdef FPCC_BRANCH_EN
      , .br_valid(br_valid), .br_taken(br_taken)
`endif
   );

   // Stand-in ALU: integer arithmetic and unsigned compares are enough to trace data movement.
   function automatic logic [32:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         3'b010:  return {1'b0, a + b};
         3'b011:  return {1'b0, a - b};
         3'b100:  return {1'b0, b};
         3'b101:  return {a == b, 32'h0};
         3'b110:  return {a < b, 32'h0};
         3'b111:  return {a <= b, 32'h0};
         default: return 33'h0;
      endcase
   endfunction

   assign {alu_cmp, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

   function automatic void bdecode(input logic [31:0] w, output int k, output logic [2:0] c);
      k = K_ILL;
      c = 3'b000;
      if (w[31:26] == 6'b010001 && w[25:21] == 5'b10000) begin
         case (w[5:0])
            6'b000000: c = 3'b010;
            6'b000001: c = 3'b011;
            6'b000110: c = 3'b100;
            6'b110010: c = 3'b101;
            6'b111100: c = 3'b110;
            6'b111110: c = 3'b111;
            default:   c = 3'b000;
         endcase
         if (c != 3'b000) k = K_ALU;
      end
`ifdef FPCC_BRANCH_EN
      if (w[31:26] == 6'b010001 && w[25:21] == 5'b01000) k = K_BR;
`endif
   endfunction

   function automatic logic [31:0] fop(input logic [5:0] fn, input logic [4:0] fs, input logic [4:0] ft,
                                       input logic [4:0] fd);
      return {6'b010001, 5'b10000, ft, fs, fd, fn};
   endfunction

   // ---------------- model: per accepted instruction, outputs are fixed offsets from the accept edge
   logic [31:0] m_rf [32];
   logic        m_fcc = 1'b0;
   logic [31:0] m_a = 32'h0, m_b = 32'h0, m_res = 32'h0;
   logic        m_cmp = 1'b0;
   bit          pend = 1'b0;
   int          p_acc = 0, p_kind = 0;
   logic [2:0]  p_code = 3'b000;
   logic [4:0]  p_fs = 5'd0, p_ft = 5'd0, p_fd = 5'd0;
   logic        p_taken = 1'b0;
   int          edge_n = 0, last_acc = -10;
   bit          e_ready = 1'b1, e_done = 1'b0, e_ill = 1'b0, e_brv = 1'b0, e_brt = 1'b0;
   logic [2:0]  e_ctrl = 3'b000;

   always @(posedge clk) begin : model
      logic [32:0] r;
      edge_n = edge_n + 1;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
         m_fcc = 1'b0; m_a = 32'h0; m_b = 32'h0; pend = 1'b0;
      end else begin
         if (pend && p_kind == K_ALU && edge_n == p_acc + 1) begin
            if (p_code == 3'b100) begin m_a = 32'h0; m_b = m_rf[p_fs]; end
            else begin m_a = m_rf[p_fs]; m_b = m_rf[p_ft]; end
            r = alu_fn(p_code, m_a, m_b);
            m_res = r[31:0];
            m_cmp = r[32];
         end
         if (ld_we) m_rf[ld_addr] = ld_data;
         if (pend && p_kind == K_ALU && edge_n == p_acc + 3) begin
            if (p_code >= 3'b101) m_fcc = m_cmp;
            else m_rf[p_fd] = m_res;
         end
         if (pend && edge_n >= p_acc + ((p_kind == K_ALU) ? 3 : 1)) pend = 1'b0;
         if (e_ready && in_valid) begin
            bdecode(instr, p_kind, p_code);
            p_fs = instr[15:11]; p_ft = instr[20:16]; p_fd = instr[10:6];
            p_taken = (m_fcc == instr[16]);
            p_acc = edge_n; pend = 1'b1; last_acc = edge_n;
         end
      end
      e_ready = !pend;
      e_ill   = pend && p_kind == K_ILL && edge_n == p_acc;
      e_brv   = pend && p_kind == K_BR && edge_n == p_acc;
      e_brt   = e_brv && p_taken;
      e_done  = pend && p_kind == K_ALU && edge_n == p_acc + 2;
      e_ctrl  = (pend && p_kind == K_ALU && (edge_n == p_acc + 1 || edge_n == p_acc + 2)) ? p_code : 3'b000;
   end

   // ---------------- checking
   int n_checks = 0, n_pass = 0;
   bit running = 1'b1;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h (edge %0d)", nm, act, exp, edge_n);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk32(nm, {31'd0, act}, {31'd0, exp});
   endtask

   always @(negedge clk) begin
      if (edge_n >= 1 && running) begin
         chk1("in_ready", in_ready, e_ready);
         chk1("done", done, e_done);
         chk1("illegal", illegal, e_ill);
         chk1("fcc", fcc, m_fcc);
         chk32("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, e_ctrl});
         chk32("alu_a", alu_a, m_a);
         chk32("alu_b", alu_b, m_b);
         chk32("st_data", st_data, m_rf[st_addr]);
`ifdef FPCC_BRANCH_EN
         chk1("br_valid", br_valid, e_brv);
         chk1("br_taken", br_taken, e_brt);
`endif
      end
   end

   // ---------------- stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [4:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_we = 1'b0;
   endtask

   // Returns one time step after the accept edge, i.e. inside the decode cycle.
   task automatic issue(input logic [31:0] w);
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      instr = w;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (last_acc == edge_n) begin got = 1'b1; break; end
      end
      in_valid = 1'b0;
      if (!got) begin
         n_checks++;
         $display("FAIL accept_timeout: got no accept, want accept within 12 cycles (edge %0d)", edge_n);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [5:0]  fn;
      int          s;
      w = $urandom;
      s = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
         0:       fn = 6'b000000;
         1:       fn = 6'b000001;
         2:       fn = 6'b000110;
         3:       fn = 6'b110010;
         4:       fn = 6'b111100;
         default: fn = 6'b111110;
      endcase
      if (s <= 5) w = {6'b010001, 5'b10000, 2'b00, w[18:16], 2'b00, w[13:11], 2'b00, w[8:6], fn};
      else if (s == 6) w = {6'b010001, 5'b01000, w[20:0]};
      else if (s == 7) w = {6'b010001, 5'b10000, w[20:0]};
      else if (s == 8) w = {6'b010001, w[25:0]};
      return w;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      st_addr = 5'd0;
      @(negedge clk);
      chk1("rst_ready", in_ready, 1'b1);
      chk32("rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
      chk1("rst_fcc", fcc, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk32("rst_f0", st_data, 32'h0);
      chk32("rst_a", alu_a, 32'h0);

      // add.s f3,f1,f2
      ld(5'd1, 32'h3F800000);
      ld(5'd2, 32'h3F800000);
      issue(fop(6'b000000, 5'd1, 5'd2, 5'd3));
      @(negedge clk);
      chk1("add_c1_ready", in_ready, 1'b0);
      chk1("add_c1_ill", illegal, 1'b0);
      tick(); @(negedge clk);
      chk32("add_ctrl", {29'd0, alu_ctrl}, 32'd2);
      chk32("add_a", alu_a, 32'h3F800000);
      chk32("add_b", alu_b, 32'h3F800000);
      tick(); @(negedge clk);
      chk1("add_done_c3", done, 1'b1);
      tick(); st_addr = 5'd3; @(negedge clk);
      chk32("add_f3", st_data, 32'h7F000000);
      chk32("model_f3", m_rf[3], 32'h7F000000);
      chk1("add_ready_c4", in_ready, 1'b1);

      // mov.s f5,f4
      ld(5'd4, 32'h40000000);
      issue(fop(6'b000110, 5'd4, 5'd0, 5'd5));
      tick(); @(negedge clk);
      chk32("mov_ctrl", {29'd0, alu_ctrl}, 32'd4);
      chk32("mov_a", alu_a, 32'h0);
      chk32("mov_b", alu_b, 32'h40000000);
      tick(); tick(); st_addr = 5'd5; @(negedge clk);
      chk32("mov_f5", st_data, 32'h40000000);
      chk1("mov_fcc", fcc, 1'b0);

      // c.eq.s f1,f2 then c.lt.s f4,f1
      issue(fop(6'b110010, 5'd1, 5'd2, 5'd0));
      tick(); tick(); tick(); st_addr = 5'd0; @(negedge clk);
      chk1("ceq_fcc", fcc, 1'b1);
      chk32("ceq_f0", st_data, 32'h0);
      issue(fop(6'b111100, 5'd4, 5'd1, 5'd0));
      tick(); tick(); tick(); st_addr = 5'd4; @(negedge clk);
      chk1("clt_fcc", fcc, 1'b0);
      chk32("clt_f4", st_data, 32'h40000000);

      // non-COP1 word
      issue(32'h00000020);
      @(negedge clk);
      chk1("ill_pulse", illegal, 1'b1);
      chk1("ill_c1_ready", in_ready, 1'b0);
      tick(); st_addr = 5'd3; @(negedge clk);
      chk1("ill_c2_ready", in_ready, 1'b1);
      chk32("ill_f3", st_data, 32'h7F000000);

      // reset during EXEC of add.s f6
      issue(fop(6'b000000, 5'd1, 5'd2, 5'd6));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      st_addr = 5'd6;
      @(negedge clk);
      chk1("rst_exec_ready", in_ready, 1'b1);
      chk1("rst_exec_done", done, 1'b0);
      chk32("rst_exec_f6", st_data, 32'h0);
      tick(); @(negedge clk);
      chk1("rst_exec_done2", done, 1'b0);

      // load and writeback to the same register in the same cycle
      ld(5'd1, 32'h00001234);
      ld(5'd2, 32'h00000011);
      issue(fop(6'b000000, 5'd1, 5'd2, 5'd7));
      tick(); tick();
      ld_we = 1'b1; ld_addr = 5'd7; ld_data = 32'hDEADBEEF;
      tick();
      ld_we = 1'b0; st_addr = 5'd7;
      @(negedge clk);
      chk32("wb_wins_f7", st_data, 32'h00001245);

      // bc1t / bc1f with fcc set
      issue(fop(6'b110010, 5'd1, 5'd1, 5'd0));
      tick(); tick(); tick(); @(negedge clk);
      chk1("bc_fcc", fcc, 1'b1);
      issue({6'b010001, 5'b01000, 5'b00001, 16'h0000});
      @(negedge clk);
`ifdef FPCC_BRANCH_EN
      chk1("bc1t_valid", br_valid, 1'b1);
      chk1("bc1t_taken", br_taken, 1'b1);
      chk1("bc1t_ill", illegal, 1'b0);
`else
      chk1("bc1t_ill", illegal, 1'b1);
`endif
      tick(); @(negedge clk);
      chk1("bc1t_ready", in_ready, 1'b1);
      issue({6'b010001, 5'b01000, 5'b00000, 16'h0000});
      @(negedge clk);
`ifdef FPCC_BRANCH_EN
      chk1("bc1f_valid", br_valid, 1'b1);
      chk1("bc1f_taken", br_taken, 1'b0);
`else
      chk1("bc1f_ill", illegal, 1'b1);
`endif
      tick(); tick(); @(negedge clk);
      chk1("bc_no_done", done, 1'b0);

      // random traffic, checked by the per-cycle compare process
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 199) == 0);
         in_valid = $urandom_range(0, 1);
         instr    = rand_instr();
         ld_we    = ($urandom_range(0, 9) < 3);
         ld_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         ld_data  = $urandom;
         st_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; ld_we = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      @(negedge clk);
      running = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
